// File: rtl/mem_arbiter.sv
// mem_arbiter -- single-port memory arbiter for the shared memory bus.
//
// CHANNELS requesters (0 = instruction fetch, 1 = load/store, rest spare)
// compete for one memory port through valid/ready handshakes. The accepted
// request is registered onto mem_*. Every access, read or write, returns one
// response LATENCY+1 cycles after acceptance. Responses come back in order and
// are tagged to the issuing channel.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/ready/we    per-channel handshake and write enable (ready is combinational)
//   req_addr, req_wdata   flat buses, channel i at [i*W +: W]
//   rsp_valid, rsp_rdata  one-cycle response strobe and shared read data
//   mem_en/we/addr/wdata  registered memory command
//   mem_rdata             memory read data, valid LATENCY cycles after mem_en
//
// Build option: define MEM_ARBITER_ROUND_ROBIN_EN to get round-robin
// arbitration. Without it the arbiter uses fixed priority, where the
// lowest-index valid channel wins.

module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int CHANNELS = 2,
  parameter int LATENCY  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CHANNELS-1:0]        req_valid,
  output logic [CHANNELS-1:0]        req_ready,
  input  logic [CHANNELS-1:0]        req_we,
  input  logic [CHANNELS*ADDR_W-1:0] req_addr,
  input  logic [CHANNELS*DATA_W-1:0] req_wdata,
  output logic [CHANNELS-1:0]        rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata
);

  localparam int IDW = $clog2(CHANNELS);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
    logic           we;
  } tag_t;

  logic [CHANNELS-1:0][ADDR_W-1:0] addr_a;
  logic [CHANNELS-1:0][DATA_W-1:0] wdata_a;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_unpack
    assign addr_a[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  logic [CHANNELS-1:0] gnt;
  logic [IDW-1:0]      gnt_id;
  logic                xfer;

  logic                mem_en_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  tag_t                tag_q [LATENCY:0];

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic [IDW-1:0] ptr_q;

  // The search starts one past the last granted channel. Because the pointer
  // resets to CHANNELS-1, channel 0 gets the first grant after reset.
  always_comb begin
    logic [IDW-1:0] cand;
    logic           found;
    gnt_id = '0;
    found  = 1'b0;
    cand   = '0;
    for (int off = 1; off <= CHANNELS; off++) begin
      cand = IDW'((int'(ptr_q) + off) % CHANNELS);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        gnt_id = cand;
      end
    end
    gnt = '0;
    if (found && rst_n) gnt[gnt_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ptr_q <= IDW'(CHANNELS - 1);
    else if (xfer) ptr_q <= gnt_id;
  end
`else
  always_comb begin
    logic found;
    gnt_id = '0;
    found  = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!found && req_valid[i]) begin
        found  = 1'b1;
        gnt_id = IDW'(i);
      end
    end
    gnt = '0;
    if (found && rst_n) gnt[gnt_id] = 1'b1;
  end
`endif

  assign req_ready = gnt;
  assign xfer      = |gnt;

  // Memory command register and tag pipeline. tag_q[0] is loaded when the
  // request is accepted. tag_q[LATENCY] lines up with mem_rdata for that access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int k = 0; k <= LATENCY; k++) tag_q[k] <= '0;
    end else begin
      mem_en_q <= xfer;
      mem_we_q <= xfer & req_we[gnt_id];
      if (xfer) begin
        mem_addr_q  <= addr_a[gnt_id];
        mem_wdata_q <= wdata_a[gnt_id];
      end
      tag_q[0] <= '{vld: xfer, id: gnt_id, we: req_we[gnt_id]};
      for (int k = 1; k <= LATENCY; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Write responses return zero data. rsp_rdata is also zero when no
  // response is being delivered.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    if (tag_q[LATENCY].vld) begin
      rsp_valid[tag_q[LATENCY].id] = 1'b1;
      if (!tag_q[LATENCY].we) rsp_rdata = mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int CH  = 3;
  localparam int LAT = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CH-1:0]     req_valid, req_ready, req_we, rsp_valid;
  logic [CH*AW-1:0]  req_addr;
  logic [CH*DW-1:0]  req_wdata;
  logic [DW-1:0]     rsp_rdata, mem_wdata, mem_rdata;
  logic              mem_en, mem_we;
  logic [AW-1:0]     mem_addr;

  logic [AW-1:0]     s_addr [CH];
  logic [DW-1:0]     s_wd   [CH];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CHANNELS(CH), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < CH; i++) begin
      req_addr[i*AW +: AW]  = s_addr[i];
      req_wdata[i*DW +: DW] = s_wd[i];
    end
  end

  function automatic logic [31:0] data_of(logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // Memory model: read data appears LAT cycles after mem_en. Non-read cycles
  // load junk so a write response that leaks mem_rdata is visible.
  logic [DW-1:0] dl [LAT];
  always @(posedge clk) begin
    dl[0] <= (mem_en && !mem_we) ? data_of(mem_addr) : 32'hBAD0_BAD0;
    for (int k = 1; k < LAT; k++) dl[k] <= dl[k-1];
  end
  assign mem_rdata = dl[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int model_grant(input logic [CH-1:0] v, input int p);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    for (int o = 1; o <= CH; o++) if (v[(p + o) % CH]) return (p + o) % CH;
`else
    for (int i = 0; i < CH; i++) if (v[i]) return i;
`endif
    return -1;
  endfunction

  typedef struct {
    int          due;
    int          ch;
    logic [31:0] data;
  } exp_t;

  exp_t          sbq [$];
  int            ptr_m;
  logic          exp_en, exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wd;
  logic [CH-1:0] gnt_last;

  // Reference monitor. It predicts the grant, pushes the expected response
  // onto the scoreboard, and checks mem_* and rsp_* every cycle.
  initial begin
    int            gi;
    logic [CH-1:0] gm;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ptr_m    = CH - 1;
        exp_en   = 1'b0;
        gnt_last = '0;
        sbq.delete();
      end else begin
        gi = model_grant(req_valid, ptr_m);
        gm = '0;
        if (gi >= 0) gm[gi] = 1'b1;
        chk("req_ready", req_ready, gm);
        chk("mem_en", mem_en, exp_en);
        if (exp_en) begin
          chk("mem_we", mem_we, exp_we);
          chk("mem_addr", mem_addr, exp_addr);
          if (exp_we) chk("mem_wdata", mem_wdata, exp_wd);
        end
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
          chk("rsp_valid", rsp_valid, 64'(1) << sbq[0].ch);
          chk("rsp_rdata", rsp_rdata, sbq[0].data);
          void'(sbq.pop_front());
        end else begin
          chk("rsp_idle_valid", rsp_valid, 0);
          chk("rsp_idle_rdata", rsp_rdata, 0);
        end
        exp_en = (gi >= 0);
        if (gi >= 0) begin
          exp_we   = req_we[gi];
          exp_addr = s_addr[gi];
          exp_wd   = s_wd[gi];
          e.due  = cyc + 1 + LAT;
          e.ch   = gi;
          e.data = req_we[gi] ? 32'h0 : data_of(s_addr[gi]);
          sbq.push_back(e);
          ptr_m = gi;
        end
        gnt_last = gm;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    repeat (n) step();
  endtask

  initial begin
    logic [CH-1:0] exp_g;
    req_valid = '0;
    req_we    = '0;
    for (int i = 0; i < CH; i++) begin
      s_addr[i] = '0;
      s_wd[i]   = '0;
    end

    // Reset values.
    repeat (3) step();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    req_valid = '1;
    #1;
    chk("rst_req_ready", req_ready, 0);
    rst_n = 1'b1;

    // All channels contend. The first grant after reset goes to channel 0.
    for (int i = 0; i < CH; i++) s_addr[i] = 32'h1000 + 32'(i * 4);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      exp_g = CH'(1) << (k % CH);
`else
      exp_g = CH'(1);
`endif
      chk("contention_grant", req_ready, exp_g);
      step();
    end
    idle(LAT + 2);

    // Single read on channel 1.
    req_valid[1] = 1'b1; req_we[1] = 1'b0; s_addr[1] = 32'h100;
    step();
    idle(LAT + 2);

    // Write on channel 0. The response carries zero data.
    req_valid[0] = 1'b1; req_we[0] = 1'b1; s_addr[0] = 32'h40; s_wd[0] = 32'h1234_5678;
    step();
    idle(LAT + 2);

    // Random traffic. Requests hold until granted.
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < CH; c++) begin
        if (!req_valid[c] || gnt_last[c]) begin
          req_valid[c] = ($urandom_range(0, 3) != 0);
          req_we[c]    = $urandom_range(0, 1) == 1;
          s_addr[c]    = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
          s_wd[c]      = $urandom;
        end
      end
      step();
    end
    idle(LAT + 3);
    chk("drain_empty", sbq.size(), 0);

    // Reset while a read is in flight.
    req_valid[0] = 1'b1; req_we[0] = 1'b0; s_addr[0] = 32'h200;
    step();
    req_valid = '0;
    req_valid[1] = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_en", mem_en, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_req_ready", req_ready, 0);
    req_valid = '0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clk);
      chk("post_reset_rsp", rsp_valid, 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
